// File: rtl/reg_port_arbiter.sv
// Two-requester round-robin arbiter for a shared register-unit port.
// Optional tenure limit (forced handoff after 4 owned cycles) enabled by ARB_TENURE_LIMIT_EN.
module reg_port_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQA,
  input  logic [2:0] RSELA,
  input  logic       WRA,
  input  logic [1:0] WSELA,
  input  logic       REQB,
  input  logic [2:0] RSELB,
  input  logic       WRB,
  input  logic [1:0] WSELB,
  output logic       GNTA,
  output logic       GNTB,
  output logic       OE,
  output logic [2:0] RSEL,
  output logic       WREN,
  output logic [1:0] WSEL,
  output logic       DSEL
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t state;
  logic   last;     // previous owner: 0 = A, 1 = B
  logic   limit;

`ifdef ARB_TENURE_LIMIT_EN
  logic [2:0] tenure;
  logic [2:0] tenure_inc;

  assign tenure_inc = (tenure == 3'd4) ? 3'd4 : tenure + 3'd1;
  // Judged on the incremented count so the owner keeps the port for exactly 4 cycles.
  assign limit = (tenure_inc == 3'd4);
`else
  assign limit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      last  <= 1'b1;
`ifdef ARB_TENURE_LIMIT_EN
      tenure <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (REQA && (!REQB || last)) begin
            state <= OWN_A;
            last  <= 1'b0;
          end else if (REQB) begin
            state <= OWN_B;
            last  <= 1'b1;
          end
`ifdef ARB_TENURE_LIMIT_EN
          tenure <= '0;
`endif
        end
        OWN_A: begin
          if (!REQA || (limit && REQB)) begin
            if (REQB) begin
              state <= OWN_B;
              last  <= 1'b1;
            end else begin
              state <= IDLE;
            end
`ifdef ARB_TENURE_LIMIT_EN
            tenure <= '0;
`endif
          end else begin
`ifdef ARB_TENURE_LIMIT_EN
            tenure <= tenure_inc;
`endif
          end
        end
        OWN_B: begin
          if (!REQB || (limit && REQA)) begin
            if (REQA) begin
              state <= OWN_A;
              last  <= 1'b0;
            end else begin
              state <= IDLE;
            end
`ifdef ARB_TENURE_LIMIT_EN
            tenure <= '0;
`endif
          end else begin
`ifdef ARB_TENURE_LIMIT_EN
            tenure <= tenure_inc;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset overrides the registered state so a write cannot escape in the reset cycle.
  always_comb begin
    GNTA = 1'b0;
    GNTB = 1'b0;
    OE   = 1'b1;
    RSEL = '0;
    WREN = 1'b1;
    WSEL = '0;
    DSEL = 1'b0;
    if (!RST) begin
      case (state)
        OWN_A: begin
          GNTA = 1'b1;
          OE   = 1'b0;
          RSEL = RSELA;
          WSEL = WSELA;
          WREN = ~(WRA & REQA);
          DSEL = 1'b0;
        end
        OWN_B: begin
          GNTB = 1'b1;
          OE   = 1'b0;
          RSEL = RSELB;
          WSEL = WSELB;
          WREN = ~(WRB & REQB);
          DSEL = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
